// File: rtl/spi_slave_regif.sv
// SPI mode-0 responder turning command/address/data frames into register bus strobes.
// Optional SPI_SLAVE_STATUS_EN shifts a status byte out on sdo during the command byte.
module spi_slave_regif #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  spi_clk_i,
   input  logic                  spi_cs_n_i,
   input  logic                  spi_sdi_i,
   output logic                  spi_sdo_o,
   output logic                  spi_sdo_oe_o,
   output logic [ADDR_WIDTH-1:0] reg_addr_o,
   output logic [31:0]           reg_wdata_o,
   output logic                  reg_we_o,
   output logic                  reg_re_o,
   input  logic [31:0]           reg_rdata_i,
   output logic                  frame_done_o,
   output logic                  frame_err_o
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
   logic sck, cs, sdi, sck_q, cs_q, armed;
   logic sck_rise, sck_fall, cs_rise, cs_fall;

   assign sck = sck_sync[SYNC_STAGES-1];
   assign cs  = cs_sync[SYNC_STAGES-1];
   assign sdi = sdi_sync[SYNC_STAGES-1];

   // armed only rises once cs_n has really been seen high, so a reset in
   // the middle of a frame cannot manufacture a false cs_n fall.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sck_sync <= '0;
         cs_sync  <= '0;
         sdi_sync <= '0;
         sck_q    <= 1'b0;
         cs_q     <= 1'b0;
         armed    <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clk_i};
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
         sck_q    <= sck;
         cs_q     <= cs;
         armed    <= armed | cs;
      end
   end

   assign sck_rise     = sck & ~sck_q;
   assign sck_fall     = ~sck & sck_q;
   assign cs_fall      = armed & cs_q & ~cs;
   assign cs_rise      = cs & ~cs_q;
   assign spi_sdo_oe_o = armed & ~cs;

   state_t                state;
   logic [4:0]            cnt;
   logic [30:0]           shift_in;
   logic [31:0]           rx_word, tx, prefetch;
   logic [7:0]            rx_byte;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  is_write, sampled, rd_pend;
   logic                  word_done, end_done, end_err;

   assign rx_word = {shift_in, sdi};
   assign rx_byte = rx_word[7:0];

   always_comb begin
      word_done = sck_rise && (state == WR_DATA) && (cnt == 5'd31);
      end_done  = 1'b0;
      end_err   = 1'b0;
      if (cs_rise) begin
         case (state)
            IDLE:    ;
            WR_DATA: if (cnt == 5'd0 || word_done) end_done = 1'b1; else end_err = 1'b1;
            RD_DATA: if (cnt == 5'd0) end_done = 1'b1; else end_err = 1'b1;
            default: end_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         shift_in     <= '0;
         tx           <= '0;
         prefetch     <= '0;
         addr         <= '0;
         is_write     <= 1'b0;
         sampled      <= 1'b0;
         rd_pend      <= 1'b0;
         reg_addr_o   <= '0;
         reg_wdata_o  <= '0;
         reg_we_o     <= 1'b0;
         reg_re_o     <= 1'b0;
         frame_done_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         reg_we_o     <= 1'b0;
         reg_re_o     <= 1'b0;
         rd_pend      <= reg_re_o;
         frame_done_o <= end_done;
         frame_err_o  <= end_err;
         if (cs_fall) begin
            state   <= CMD;
            cnt     <= '0;
            sampled <= 1'b0;
         end else if (cs_rise) begin
            state <= IDLE;
            cnt   <= '0;
            if (word_done) begin
               reg_we_o    <= 1'b1;
               reg_wdata_o <= rx_word;
               reg_addr_o  <= addr;
               addr        <= addr + 1'b1;
            end
         end else begin
            case (state)
               CMD: begin
                  if (sck_rise) begin
                     shift_in <= rx_word[30:0];
                     sampled  <= 1'b1;
                     cnt      <= cnt + 5'd1;
                     if (cnt == 5'd7) begin
                        cnt <= '0;
                        case (rx_byte)
                           8'h01:   begin is_write <= 1'b1; state <= ADDR; end
                           8'h02:   begin is_write <= 1'b0; state <= ADDR; end
                           default: state <= IGNORE;
                        endcase
                     end
                  end else if (sck_fall) begin
                     sampled <= 1'b0;
                  end
               end
               ADDR: begin
                  if (rd_pend) begin
                     tx      <= reg_rdata_i;
                     sampled <= 1'b0;
                     state   <= RD_DATA;
                  end else if (sck_rise) begin
                     shift_in <= rx_word[30:0];
                     cnt      <= cnt + 5'd1;
                     if (cnt == 5'd7) begin
                        cnt  <= '0;
                        addr <= rx_byte[ADDR_WIDTH-1:0];
                        if (is_write) begin
                           state <= WR_DATA;
                        end else begin
                           reg_re_o   <= 1'b1;
                           reg_addr_o <= rx_byte[ADDR_WIDTH-1:0];
                        end
                     end
                  end
               end
               WR_DATA: begin
                  if (sck_rise) begin
                     shift_in <= rx_word[30:0];
                     cnt      <= cnt + 5'd1;
                     if (cnt == 5'd31) begin
                        reg_we_o    <= 1'b1;
                        reg_wdata_o <= rx_word;
                        reg_addr_o  <= addr;
                        addr        <= addr + 1'b1;
                     end
                  end
               end
               RD_DATA: begin
                  if (rd_pend) prefetch <= reg_rdata_i;
                  // Halfway through a word, fetch the next one so it is ready for the word boundary.
                  if (sck_rise) begin
                     cnt     <= cnt + 5'd1;
                     sampled <= 1'b1;
                     if (cnt == 5'd15) begin
                        reg_re_o   <= 1'b1;
                        reg_addr_o <= addr + 1'b1;
                     end
                  end else if (sck_fall && sampled) begin
                     sampled <= 1'b0;
                     if (cnt == 5'd0) begin
                        tx   <= prefetch;
                        addr <= addr + 1'b1;
                     end else begin
                        tx <= {tx[30:0], 1'b0};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SPI_SLAVE_STATUS_EN
   logic [7:0] stat_sh;
   logic       last_err, last_wr, wr_seen;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_sh  <= '0;
         last_err <= 1'b0;
         last_wr  <= 1'b0;
         wr_seen  <= 1'b0;
      end else begin
         if (cs_fall) begin
            stat_sh <= {4'hA, 2'b00, last_err, last_wr};
            wr_seen <= 1'b0;
         end else begin
            if (state == CMD && sck_fall && sampled) stat_sh <= {stat_sh[6:0], 1'b0};
            if (reg_we_o) wr_seen <= 1'b1;
         end
         if (cs_rise && state != IDLE) begin
            last_err <= end_err;
            last_wr  <= wr_seen | reg_we_o | word_done;
         end
      end
   end

   assign spi_sdo_o = (state == RD_DATA) ? tx[31] : ((state == CMD) & stat_sh[7]);
`else
   assign spi_sdo_o = (state == RD_DATA) & tx[31];
`endif

endmodule

// File: doc/spi_slave_regif.md
Name: spi_slave_regif

Overview:
SPI mode-0 responder for the APB SPI master's frames. It decodes a command byte, an address byte and then 32-bit data words, and turns them into single-cycle register write/read strobes on a local register bus. It sits on the device side of the SPI link and is clocked by the system clock, so all SPI pins are oversampled.

Parameters:
ADDR_WIDTH, 4, register address width; the low bits of the address byte are used.
SYNC_STAGES, 2, synchroniser depth on spi_clk_i, spi_cs_n_i and spi_sdi_i (minimum 2).

Ports:
clk_i  in  1  system clock; must be at least 4x the spi_clk_i rate.
rst_i  in  1  asynchronous, active-high reset.
spi_clk_i  in  1  SPI clock from the master; idles low (mode 0).
spi_cs_n_i  in  1  chip select, active low.
spi_sdi_i  in  1  data from the master, MSB first.
spi_sdo_o  out  1  data to the master, MSB first.
spi_sdo_oe_o  out  1  output enable for sdo; high only while cs is active.
reg_addr_o  out  ADDR_WIDTH  register bus address.
reg_wdata_o  out  32  register write data.
reg_we_o  out  1  one-cycle write strobe.
reg_re_o  out  1  one-cycle read strobe.
reg_rdata_i  in  32  read data; must be valid on the cycle after reg_re_o.
frame_done_o  out  1  one-cycle pulse when cs_n deasserts after a valid frame.
frame_err_o  out  1  one-cycle pulse when cs_n deasserts after an invalid or truncated frame.

Behaviour:
- Reset: all outputs are 0, and the FSM is in IDLE.
- Clocking: the three SPI inputs pass through SYNC_STAGES flops. A rise or fall is detected by comparing the synchronised value with its previous value.
- Data edges: sdi is sampled on a detected spi_clk rise. sdo changes on a detected spi_clk fall.
- Framing: a detected cs_n fall moves the FSM to CMD and clears the bit counter (0..31). A detected cs_n rise returns the FSM to IDLE from any state.
- FSM states: IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE.
- CMD state: after 8 bits, the command decides the next state.
  - 0x01: write, go to ADDR.
  - 0x02: read, go to ADDR.
  - Any other value: go to IGNORE; the error flag is set.
- ADDR state: after 8 bits, addr = byte[ADDR_WIDTH-1:0].
  - Write: go to WR_DATA.
  - Read: assert reg_re_o with addr on the next clk_i, load reg_rdata_i into the tx shifter one cycle later, then go to RD_DATA.
- WR_DATA state:
  - The shifter collects 32 bits.
  - On the clk_i after the 32nd bit is sampled, reg_we_o=1 for exactly one cycle, with reg_addr_o=addr and reg_wdata_o=word.
  - addr then increments and wraps modulo 2^ADDR_WIDTH.
  - Further words repeat this process.
- RD_DATA state:
  - The MSB of the loaded word is on sdo before the first data-phase spi_clk rise.
  - When the 16th bit of a word is sampled, the block prefetches the next word: reg_re_o is asserted with addr+1 (wrapping) and the result is held in a prefetch register.
  - After the 32nd bit, the next spi_clk fall loads the shifter from the prefetch register, and addr increments.
- sdo outside the data phase: sdo=0 in CMD, ADDR, WR_DATA and IGNORE.
- spi_sdo_oe_o: equals the synchronised ~cs_n.
- Truncated frame: if cs_n rises with the bit counter nonzero in ADDR, WR_DATA or RD_DATA, the partial word is discarded, no reg_we_o is issued, and frame_err_o is pulsed.
- Clean end: a cs_n rise with the counter at 0 in WR_DATA or RD_DATA pulses frame_done_o.
- Frame ends before any data: a cs_n rise in CMD, or in ADDR with zero bits, pulses frame_err_o.
- Simultaneous events: if a cs_n rise and the 32nd-bit write completion are detected in the same cycle, the write is issued and frame_done_o is pulsed.
- Reset mid-frame: the block returns to IDLE and ignores the remaining SPI edges until the next cs_n fall.

Optional Feature:
SPI_SLAVE_STATUS_EN.
- Defined: during the CMD byte, sdo shifts out the status byte {4'hA, 2'b00, last_err, last_was_write}, where last_* are registered at the end of the previous frame and reset to 0.
- Undefined: sdo is 0 during CMD and the status registers are not built.

Test Plan:
1. Write frame. Drive cs low, then send bytes 0x01, 0x03 and data 0xABCD1234 -> reg_we_o pulses once with reg_addr_o=3 and reg_wdata_o=0xABCD1234; frame_done_o pulses after cs rises.
2. Write burst with wrap. Send 0x01, 0x0F, then 0x11111111 and 0x22222222 -> writes go to addr 15 then addr 0; there are exactly 2 reg_we_o pulses.
3. Read burst. Send 0x02, 0x05 and clock 64 bits, with the model returning 0xCDEF9876 at addr 5 and 0x00000042 at addr 6 -> sdo shows 0xCDEF9876 then 0x00000042; reg_re_o fires at addr 5 and addr 6.
4. Bad command. Send 0x7E, then 40 clocks -> no reg_we_o or reg_re_o; sdo stays 0; frame_err_o pulses on cs rise.
5. Truncated write. Send 0x01, 0x02 and 20 data bits, then raise cs -> no reg_we_o; frame_err_o pulses once; the next valid frame works.
6. Reset mid-frame. Assert rst_i after 12 bits of a write frame -> outputs go to 0 immediately; the following clean frame (0x01, 0x04, 0x00000001) writes correctly.
   With SPI_SLAVE_STATUS_EN defined, the CMD byte after test 5 reads back 0xA2.
